// File: rtl/readchar_fifo.sv
// Character-input function unit: buffers bytes from a ready/valid byte source
// and hands them to the core one at a time through a triggered GETCHAR/AVAIL op.
module readchar_fifo #(
  parameter int dataw = 32,
  parameter int depth = 16,
  parameter int addrw = 4
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic [dataw-1:0] t1data,
  input  logic             t1load,
  input  logic             t1opcode,
  output logic [dataw-1:0] o1data,
  input  logic             glock,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  localparam logic [addrw:0] FULL_COUNT = (addrw+1)'(depth);

  logic [7:0]       r_mem [depth];
  logic [addrw-1:0] r_rdPtr;
  logic [addrw-1:0] r_wrPtr;
  logic [addrw:0]   r_count;
  logic [dataw-1:0] r_res;

  logic             w_push;
  logic             w_accept;
  logic             w_notEmpty;
  logic             w_pop;
  logic [dataw-1:0] w_nextRes;
  logic             w_unused;

  // The trigger operand carries no information for either opcode.
  assign w_unused = ^t1data;

  assign rx_ready   = (r_count != FULL_COUNT);
  assign w_push     = rx_valid & rx_ready;
  assign w_accept   = t1load & ~glock;
  assign w_notEmpty = (r_count != '0);
  assign w_pop      = w_accept & ~t1opcode & w_notEmpty;

  always_comb begin
    w_nextRes = r_res;
    if (w_accept) begin
      if (t1opcode) begin
        w_nextRes = {{(dataw-addrw-1){1'b0}}, r_count};
      end else if (w_notEmpty) begin
        w_nextRes = {{(dataw-8){1'b0}}, r_mem[r_rdPtr]};
      end else begin
        w_nextRes = '1;
      end
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_res   <= '0;
    end else begin
      r_res <= w_nextRes;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o1data = r_res;

endmodule

// File: tb/tb_readchar_fifo.sv
// Self-checking bench for readchar_fifo: directed scenarios plus a random
// phase, all checked against a queue-based model of the character FIFO.
module tb_readchar_fifo;

  localparam int DEPTH = 16;
  localparam logic GETCHAR = 1'b0;
  localparam logic AVAIL   = 1'b1;

  logic        clk = 1'b0;
  logic        rstx;
  logic [31:0] t1data;
  logic        t1load;
  logic        t1opcode;
  logic [31:0] o1data;
  logic        glock;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int total = 0;
  int bad = 0;

  logic [7:0]  q[$];
  logic [31:0] mRes;
  logic        srcValid;
  logic [7:0]  srcData;

  readchar_fifo #(.dataw(32), .depth(DEPTH), .addrw(4)) dut (
    .clk(clk), .rstx(rstx), .t1data(t1data), .t1load(t1load),
    .t1opcode(t1opcode), .o1data(o1data), .glock(glock),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge; the model advances
  // from the pre-edge state, outputs are checked at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ld,
                               input logic op, input logic lk, input string tag,
                               output logic pushed);
    logic popOk;
    rx_valid = v; rx_data = d; t1load = ld; t1opcode = op; glock = lk;
    t1data = $urandom;
    pushed = v && (q.size() < DEPTH);
    popOk  = ld && !lk && (op == GETCHAR) && (q.size() > 0);
    if (ld && !lk) begin
      if (op == AVAIL) mRes = 32'(q.size());
      else if (q.size() > 0) mRes = {24'h0, q[0]};
      else mRes = 32'hFFFF_FFFF;
    end
    @(posedge clk);
    if (popOk) void'(q.pop_front());
    if (pushed) q.push_back(d);
    @(negedge clk);
    checkOutput({tag, ".o1data"}, o1data, mRes);
    checkOutput({tag, ".rx_ready"}, {31'h0, rx_ready}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
  endtask

  // Cycle driven from the held source byte; the byte is retired once accepted.
  task automatic srcCycle(input logic ld, input logic op, input logic lk, input string tag);
    logic pushed;
    applyStimulus(srcValid, srcData, ld, op, lk, tag, pushed);
    if (pushed) srcValid = 1'b0;
  endtask

  task automatic idle(input logic ld, input logic op, input string tag);
    logic pushed;
    applyStimulus(1'b0, 8'h00, ld, op, 1'b0, tag, pushed);
  endtask

  task automatic pushByte(input logic [7:0] b, input string tag);
    srcValid = 1'b1; srcData = b;
    srcCycle(1'b0, GETCHAR, 1'b0, tag);
  endtask

  task automatic asyncReset(input string tag);
    #2 rstx = 1'b0;
    #1;
    q.delete();
    mRes = 32'h0;
    srcValid = 1'b0;
    checkOutput({tag, ".o1data"}, o1data, 32'h0);
    checkOutput({tag, ".rx_ready"}, {31'h0, rx_ready}, 32'd1);
    #1 rstx = 1'b1;
  endtask

  initial begin
    logic pushed;
    rstx = 1'b0; t1data = '0; t1load = 0; t1opcode = 0; glock = 0;
    rx_data = '0; rx_valid = 0; srcValid = 0; srcData = '0; mRes = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.o1data", o1data, 32'h0);
    checkOutput("reset.rx_ready", {31'h0, rx_ready}, 32'd1);
    rstx = 1'b1;
    idle(1'b1, AVAIL, "reset.avail");
    checkOutput("reset.avail.exp", mRes, 32'h0);
    idle(1'b1, GETCHAR, "reset.eof");

    // Ordering with AVAIL between pops.
    pushByte(8'h41, "ord.push");
    pushByte(8'h42, "ord.push");
    pushByte(8'h43, "ord.push");
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, AVAIL, "ord.avail");
      idle(1'b1, GETCHAR, "ord.get");
    end
    idle(1'b1, GETCHAR, "ord.eof");

    // Fill, hold the 17th byte, pop one, let it enter, drain across the wrap.
    for (int i = 0; i < DEPTH; i++) pushByte(8'(i), "full.push");
    srcValid = 1'b1; srcData = 8'h10;
    srcCycle(1'b0, GETCHAR, 1'b0, "full.held");
    srcCycle(1'b1, AVAIL, 1'b0, "full.avail");
    srcCycle(1'b1, GETCHAR, 1'b0, "full.pop");
    srcCycle(1'b0, GETCHAR, 1'b0, "full.enter");
    checkOutput("full.entered", {31'h0, srcValid}, 32'd0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1, GETCHAR, "full.drain");
    idle(1'b1, GETCHAR, "full.eof");

    // Global lock freezes the result and blocks pops.
    pushByte(8'h5A, "lock.push");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h0, 1'b1, GETCHAR, 1'b1, "lock.stall", pushed);
    idle(1'b1, AVAIL, "lock.avail");
    idle(1'b1, GETCHAR, "lock.get");

    // Simultaneous push and GETCHAR, empty and partly filled.
    applyStimulus(1'b1, 8'h33, 1'b1, GETCHAR, 1'b0, "sim.empty", pushed);
    idle(1'b1, AVAIL, "sim.avail1");
    idle(1'b1, GETCHAR, "sim.flush");
    pushByte(8'h10, "sim.push");
    pushByte(8'h11, "sim.push");
    applyStimulus(1'b1, 8'h12, 1'b1, GETCHAR, 1'b0, "sim.mid", pushed);
    idle(1'b1, AVAIL, "sim.avail2");

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) pushByte(8'(8'hA0 + i), "rst.push");
    asyncReset("rst.async");
    idle(1'b1, AVAIL, "rst.avail");
    idle(1'b1, GETCHAR, "rst.eof");

    // Random phase: push pressure alternates so the FIFO visits full and empty.
    for (int i = 0; i < 3000; i++) begin
      int pushBias;
      pushBias = ((i / 300) % 2 == 0) ? 3 : 1;
      if (!srcValid && ($urandom_range(0, 3) < pushBias)) begin
        srcValid = 1'b1;
        srcData  = 8'($urandom);
      end
      srcCycle($urandom_range(0, 3) < (4 - pushBias), 1'($urandom_range(0, 3) == 0),
               $urandom_range(0, 4) == 0, "rand");
      if (i == 1777) asyncReset("rand.reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/readchar_fifo.md
# readchar_fifo

Synthesizable TTA function unit providing the input side of the character console: it accepts bytes from an external byte-stream source (UART receiver, testbench or host bridge) into an internal FIFO, and lets the core read them one at a time with a triggered operation. It complements the stdout character-print unit, is connected to the core like any other FU (operand/trigger ports, global lock) and returns results through a single result register.

## Interface
Parameters:
- dataw, 32, width of trigger operand and result port (>= 9)
- depth, 16, FIFO entries (power of two, >= 2)
- addrw, 4, log2(depth)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstx  in  1  reset, asynchronous, active-low
- t1data  in  dataw  trigger operand (ignored; present for FU template compatibility)
- t1load  in  1  trigger strobe
- t1opcode  in  1  0 = GETCHAR, 1 = AVAIL
- o1data  out  dataw  result register
- glock  in  1  global lock; 1 = core stalled
- rx_data  in  8  incoming byte
- rx_valid  in  1  source has a byte on rx_data
- rx_ready  out  1  FIFO can accept a byte (= not full)

## Operation
- State: byte array [depth], read pointer rd (addrw), write pointer wr (addrw), count (addrw+1), result register res (dataw).
- Reset (rstx=0, asynchronous): rd=wr=0, count=0, res=0; hence o1data=0, rx_ready=1. Array contents need not be reset.
- Push: when rx_valid=1 and rx_ready=1 at a rising edge, mem[wr] <= rx_data, wr <= wr+1 (wraps modulo depth). Push is independent of glock.
- rx_ready = (count != depth), derived from registered count only; a pop in the same cycle does not make a full FIFO accept.
- Accepted trigger: t1load=1 and glock=0 at a rising edge. With glock=1, t1load is ignored, no pop, res holds.
- GETCHAR, count > 0: res <= zero-extended mem[rd]; rd <= rd+1 (wraps); count decrements.
- GETCHAR, count = 0: res <= all ones (-1, EOF); no pointer change.
- AVAIL: res <= zero-extended count (value before this edge); no pop.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Push and GETCHAR on the same edge with count=0: GETCHAR returns -1, the pushed byte is stored (count becomes 1).
- Push and GETCHAR on the same edge with 0 < count < depth: GETCHAR returns the oldest byte, the pushed byte is appended, count is unchanged.
- No overflow or underflow is possible: rejected pushes are held by the source per handshake; an empty pop returns -1.

## Timing
- Operation latency 1: trigger accepted at edge N, o1data shows the result from just after edge N until the next accepted trigger.
- A byte pushed at edge N is poppable by a trigger accepted at edge N+1 or later.
- rx_ready reflects count after each edge; a byte popped at edge N frees space, so rx_ready=1 after edge N.
- Source handshake: rx_data/rx_valid must stay stable until rx_valid & rx_ready at an edge; the FU takes exactly one byte per such edge.
- Reset asserted mid-operation discards all FIFO contents immediately; first accepted GETCHAR after release returns -1.

## Test plan
- Reset: hold rstx=0, release -> o1data=0, rx_ready=1; AVAIL -> 0; GETCHAR -> 0xFFFFFFFF.
- Order: push 0x41,0x42,0x43 on consecutive edges, then 3 GETCHARs -> 0x41, 0x42, 0x43; 4th -> 0xFFFFFFFF; AVAIL between pops -> 3, 2, 1.
- Full/wrap: push 16 bytes 0x00..0x0F -> rx_ready=0 after 16th, 17th byte held; AVAIL -> 16; pop one (0x00) -> rx_ready=1, held byte 0x10 enters; drain -> 0x01..0x10 in order (pointers wrapped).
- Lock: with one byte 0x5A queued, assert glock=1 with t1load=1 for 3 cycles -> o1data unchanged, AVAIL afterwards 1; release glock, GETCHAR -> 0x5A.
- Simultaneous: count=0, push 0x33 and GETCHAR same edge -> result 0xFFFFFFFF, AVAIL next -> 1; count=2 (0x10,0x11), push 0x12 + GETCHAR -> 0x10, AVAIL -> 2.
- Reset mid-stream: queue 5 bytes, pulse rstx low between edges -> rx_ready=1, o1data=0 asynchronously; AVAIL -> 0.
